pool2_stream: RTL and testbench

//  Streaming 2x2/stride-2 pooling unit for the CNN feature-map pipeline; parametrised successor to the fixed 8x8->4x4 pooler.

---
 rtl/cnn_pkg.sv | 20 ++
 rtl/pool2_stream_if.sv | 27 ++
 rtl/pool2_combine.sv | 34 +++
 rtl/pool2_stream.sv | 136 +++++++++++++
 tb/tb_pool2_stream.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// Shared types and defaults for the CNN pooling stage.
package cnn_pkg;

   localparam int BW_DEF = 8;

   typedef enum logic [1:0] {
      POOL_MAX  = 2'b00,
      POOL_AVG  = 2'b01,
      POOL_NAND = 2'b10,
      POOL_MIN  = 2'b11
   } pool_mode_e;

   // Horizontal stage builds a partial from two pixels of one row;
   // vertical stage merges a stored partial with the current one.
   typedef enum logic {
      STAGE_HORIZ = 1'b0,
      STAGE_VERT  = 1'b1
   } pool_stage_e;

endpackage

// File: rtl/pool2_stream_if.sv
// Pixel-in / pooled-pixel-out stream bundle for pool2_stream.
//
// Handshake: on each side a transfer happens on a rising clk edge where
// valid && ready. A source holding valid keeps data (and last) stable until
// the transfer. ready may depend combinationally on the sink's own state,
// never on the source's valid.
interface pool2_stream_if #(parameter int BW = 8);

   logic          in_valid;
   logic          in_ready;
   logic [BW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [BW-1:0] out_data;
   logic          out_last;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

endinterface

// File: rtl/pool2_combine.sv
// Combinational pooling operator shared by the horizontal and vertical stages.
// Operands are BW+1 bits so the horizontal average sum fits unmodified.
module pool2_combine
   import cnn_pkg::*;
#(
   parameter int BW = BW_DEF
) (
   input  pool_mode_e  mode,
   input  pool_stage_e stage,
   input  logic [BW:0] a,
   input  logic [BW:0] b,
   output logic [BW:0] y
);

   logic [BW+1:0] sum;
   logic          lsb_and;

   assign sum     = {1'b0, a} + {1'b0, b};
   assign lsb_and = a[0] & b[0];

   // Select the operator result for the current mode and stage.
   always_comb begin
      y = '0;
      case (mode)
         POOL_MAX:  y = (a > b) ? a : b;
         POOL_MIN:  y = (a < b) ? a : b;
         POOL_AVG:  y = (stage == STAGE_HORIZ) ? sum[BW:0] : {1'b0, sum[BW+1:2]};
         POOL_NAND: y = (stage == STAGE_HORIZ) ? {{BW{1'b0}}, lsb_and}
                                               : {{BW{1'b0}}, ~lsb_and};
         default:   y = '0;
      endcase
   end

endmodule

// File: rtl/pool2_stream.sv
// Streaming 2x2 / stride-2 pooler. Pixels arrive in raster order; even rows
// park horizontal partials in a half-width line buffer, odd rows merge them
// and load a one-entry output register.
module pool2_stream
   import cnn_pkg::*;
#(
   parameter int BW    = BW_DEF,
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [1:0]     mode,
   output logic           busy,
   pool2_stream_if.slave  s
);

   localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int LD = IMG_W / 2;
   localparam int LW = (LD > 1) ? $clog2(LD) : 1;

   if (IMG_W < 2 || (IMG_W % 2) != 0) begin : g_bad_w
      $error("pool2_stream: IMG_W must be even and >= 2");
   end
   if (IMG_H < 2 || (IMG_H % 2) != 0) begin : g_bad_h
      $error("pool2_stream: IMG_H must be even and >= 2");
   end

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   pool_mode_e    mode_q;
   logic [BW-1:0] hold;
   logic [BW:0]   lb [LD];
   logic [LW-1:0] lb_idx;
   logic [BW:0]   partial;
   logic [BW:0]   result;
   logic          accept;
   logic          col_last;
   logic          row_last;
   logic          frame_start;
   logic          out_load;
   logic          last_taken;

   assign s.in_ready  = !s.out_valid || s.out_ready;
   assign accept      = s.in_valid && s.in_ready;
   assign col_last    = (col == CW'(IMG_W - 1));
   assign row_last    = (row == RW'(IMG_H - 1));
   assign frame_start = (col == '0) && (row == '0);
   assign lb_idx      = LW'(col >> 1);
   assign out_load    = accept && row[0] && col[0];
   assign last_taken  = s.out_valid && s.out_ready && s.out_last;

   pool2_combine #(.BW(BW)) u_horiz (
      .mode  (mode_q),
      .stage (STAGE_HORIZ),
      .a     ({1'b0, hold}),
      .b     ({1'b0, s.in_data}),
      .y     (partial)
   );

   pool2_combine #(.BW(BW)) u_vert (
      .mode  (mode_q),
      .stage (STAGE_VERT),
      .a     (lb[lb_idx]),
      .b     (partial),
      .y     (result)
   );

   // Raster position counters; both wrap straight into the next frame.
   always_ff @(posedge clk) begin
      if (!rst) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col_last) begin
            col <= '0;
            row <= row_last ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Mode is latched once per frame on the first pixel.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mode_q <= POOL_MAX;
      end else if (accept && frame_start) begin
         mode_q <= pool_mode_e'(mode);
      end
   end

   // Even-column pixel waits here for its odd-column neighbour.
   always_ff @(posedge clk) begin
      if (!rst) begin
         hold <= '0;
      end else if (accept && !col[0]) begin
         hold <= s.in_data;
      end
   end

   // Even-row partials; always rewritten before the odd row reads them.
   always_ff @(posedge clk) begin
      if (accept && !row[0] && col[0]) begin
         lb[lb_idx] <= partial;
      end
   end

   // One-entry output register; a new load may coincide with a take.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s.out_valid <= 1'b0;
         s.out_data  <= '0;
         s.out_last  <= 1'b0;
      end else if (out_load) begin
         s.out_valid <= 1'b1;
         s.out_data  <= result[BW-1:0];
         s.out_last  <= col_last && row_last;
      end else if (s.out_ready) begin
         s.out_valid <= 1'b0;
      end
   end

   // Frame-in-progress flag; a new frame start wins over the old frame's end.
   always_ff @(posedge clk) begin
      if (!rst) begin
         busy <= 1'b0;
      end else if (accept && frame_start) begin
         busy <= 1'b1;
      end else if (last_taken) begin
         busy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pool2_stream.sv
// Bench for pool2_stream on a 4x4 map with BW=8.
module tb_pool2_stream;
   import cnn_pkg::*;

   localparam int BW = 8;
   localparam int W  = 4;
   localparam int H  = 4;
   localparam int N  = W * H;
   localparam int OW = BW + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] mode = 2'b00;
   logic       busy;
   logic       bp_en = 1'b0;
   logic       tx_done;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [OW-1:0] exp_q[$];
   logic [OW-1:0] got_q[$];
   int            got_t[$];

   pool2_stream_if #(.BW(BW)) ifc ();

   pool2_stream #(.BW(BW), .IMG_W(W), .IMG_H(H)) dut (
      .clk  (clk),
      .rst  (rst),
      .mode (mode),
      .busy (busy),
      .s    (ifc)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;

   // Output monitor: record every accepted pooled pixel and its cycle.
   always @(posedge clk) begin
      cyc++;
      if (rst && ifc.out_valid && ifc.out_ready) begin
         got_q.push_back({ifc.out_last, ifc.out_data});
         got_t.push_back(cyc);
      end
   end

   // Optional random backpressure.
   always @(negedge clk) begin
      if (bp_en) ifc.out_ready = ($urandom_range(0, 3) != 0);
   end

   // Reference model: pool each 2x2 window straight from the frame array.
   task automatic model_frame(input logic [BW-1:0] p[N], input logic [1:0] m);
      int a, b, c, d, r;
      logic lst;
      for (int pr = 0; pr < H / 2; pr++) begin
         for (int pc = 0; pc < W / 2; pc++) begin
            a = int'(p[2 * pr * W + 2 * pc]);
            b = int'(p[2 * pr * W + 2 * pc + 1]);
            c = int'(p[(2 * pr + 1) * W + 2 * pc]);
            d = int'(p[(2 * pr + 1) * W + 2 * pc + 1]);
            case (m)
               2'b00: begin
                  r = a;
                  if (b > r) r = b;
                  if (c > r) r = c;
                  if (d > r) r = d;
               end
               2'b01: r = (a + b + c + d) / 4;
               2'b10: r = ((a % 2) == 1 && (b % 2) == 1 && (c % 2) == 1 && (d % 2) == 1) ? 0 : 1;
               default: begin
                  r = a;
                  if (b < r) r = b;
                  if (c < r) r = c;
                  if (d < r) r = d;
               end
            endcase
            lst = (pr == H / 2 - 1) && (pc == W / 2 - 1);
            exp_q.push_back({lst, r[BW-1:0]});
         end
      end
   endtask

   // Driver: present one pixel from a negedge and wait (bounded) for acceptance.
   task automatic send_pix(input logic [BW-1:0] d, input logic [1:0] m, input int gap);
      bit acc;
      int n;
      for (int g = 0; g < gap; g++) begin
         ifc.in_valid = 1'b0;
         @(negedge clk);
      end
      ifc.in_valid = 1'b1;
      ifc.in_data  = d;
      mode         = m;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 200) begin
         @(posedge clk);
         acc = ifc.in_ready;
         n++;
      end
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL send_timeout got=in_ready_low exp=accept within 200 cycles");
      end
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [BW-1:0] p[N], input logic [1:0] m0,
                             input logic [1:0] m1, input int sw, input int maxgap);
      for (int i = 0; i < N; i++) begin
         send_pix(p[i], (i < sw) ? m0 : m1, (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
      end
   endtask

   task automatic wait_out(input int n, input int budget);
      int k = 0;
      ifc.in_valid = 1'b0;
      while (got_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic rand_frame(output logic [BW-1:0] p[N]);
      for (int i = 0; i < N; i++) p[i] = BW'($urandom_range(0, 255));
   endtask

   task automatic clear_q();
      exp_q.delete();
      got_q.delete();
      got_t.delete();
   endtask

   task automatic test_reset();
      ifc.in_valid  = 1'b0;
      ifc.in_data   = '0;
      ifc.out_ready = 1'b1;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", ifc.out_valid); end
      checks++; if (ifc.out_data !== 8'h00) begin failures++; $display("FAIL rst_out_data got=%h exp=00", ifc.out_data); end
      checks++; if (ifc.out_last !== 1'b0) begin failures++; $display("FAIL rst_out_last got=%b exp=0", ifc.out_last); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (ifc.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", ifc.in_ready); end
   endtask

   task automatic test_max_ramp();
      logic [BW-1:0] p[N];
      logic [OW-1:0] g;
      clear_q();
      for (int i = 0; i < N; i++) p[i] = BW'(i);
      model_frame(p, 2'b00);
      send_frame(p, 2'b00, 2'b00, N, 0);
      wait_out(4, 100);
      checks++; if (got_q.size() != 4) begin failures++; $display("FAIL ramp_count got=%0d exp=4", got_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (i < got_q.size()) ? got_q[i] : 'x;
         checks++; if (g !== exp_q[i]) begin failures++; $display("FAIL ramp_out idx=%0d got=%h exp=%h", i, g, exp_q[i]); end
      end
      if (got_t.size() == 4) begin
         checks++; if (got_t[1] - got_t[0] != 2) begin failures++; $display("FAIL ramp_spacing_r1 got=%0d exp=2", got_t[1] - got_t[0]); end
         checks++; if (got_t[3] - got_t[2] != 2) begin failures++; $display("FAIL ramp_spacing_r3 got=%0d exp=2", got_t[3] - got_t[2]); end
      end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ramp_busy_end got=%b exp=0", busy); end
   endtask

   task automatic test_avg();
      logic [BW-1:0] p[N];
      logic [OW-1:0] g;
      clear_q();
      rand_frame(p);
      p[0] = 8'd255; p[1] = 8'd255; p[4] = 8'd255; p[5] = 8'd254;
      p[2] = 8'd1;   p[3] = 8'd1;   p[6] = 8'd1;   p[7] = 8'd0;
      model_frame(p, 2'b01);
      send_frame(p, 2'b01, 2'b01, N, 0);
      wait_out(4, 100);
      checks++; if (got_q.size() != 4) begin failures++; $display("FAIL avg_count got=%0d exp=4", got_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (i < got_q.size()) ? got_q[i] : 'x;
         checks++; if (g !== exp_q[i]) begin failures++; $display("FAIL avg_out idx=%0d got=%h exp=%h", i, g, exp_q[i]); end
      end
      if (got_q.size() >= 2) begin
         checks++; if (got_q[0][BW-1:0] !== 8'd254) begin failures++; $display("FAIL avg_1019 got=%0d exp=254", got_q[0][BW-1:0]); end
         checks++; if (got_q[1][BW-1:0] !== 8'd0) begin failures++; $display("FAIL avg_trunc got=%0d exp=0", got_q[1][BW-1:0]); end
      end
   endtask

   task automatic test_nand();
      logic [BW-1:0] p[N];
      logic [OW-1:0] g;
      clear_q();
      rand_frame(p);
      p[0] = p[0] | 8'h01; p[1] = p[1] | 8'h01; p[4] = p[4] | 8'h01; p[5] = p[5] | 8'h01;
      p[2] = p[2] & 8'hFE;
      model_frame(p, 2'b10);
      send_frame(p, 2'b10, 2'b10, N, 0);
      wait_out(4, 100);
      checks++; if (got_q.size() != 4) begin failures++; $display("FAIL nand_count got=%0d exp=4", got_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (i < got_q.size()) ? got_q[i] : 'x;
         checks++; if (g !== exp_q[i]) begin failures++; $display("FAIL nand_out idx=%0d got=%h exp=%h", i, g, exp_q[i]); end
      end
      if (got_q.size() >= 2) begin
         checks++; if (got_q[0][BW-1:0] !== 8'h00) begin failures++; $display("FAIL nand_all_ones got=%h exp=00", got_q[0][BW-1:0]); end
         checks++; if (got_q[1][BW-1:0] !== 8'h01) begin failures++; $display("FAIL nand_one_zero got=%h exp=01", got_q[1][BW-1:0]); end
      end
   endtask

   task automatic test_stall();
      logic [BW-1:0] p[N];
      logic [OW-1:0] g;
      logic [BW-1:0] held;
      int k;
      clear_q();
      rand_frame(p);
      model_frame(p, 2'b00);
      tx_done = 1'b0;
      fork
         begin
            send_frame(p, 2'b00, 2'b00, N, 0);
            ifc.in_valid = 1'b0;
            tx_done = 1'b1;
         end
      join_none
      k = 0;
      while (!ifc.out_valid && k < 100) begin
         @(negedge clk);
         k++;
      end
      checks++; if (ifc.out_valid !== 1'b1) begin failures++; $display("FAIL stall_first_valid got=%b exp=1", ifc.out_valid); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stall_busy_mid got=%b exp=1", busy); end
      ifc.out_ready = 1'b0;
      held = ifc.out_data;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++; if (ifc.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", c, ifc.in_ready); end
         checks++; if (ifc.out_data !== held || ifc.out_valid !== 1'b1) begin
            failures++; $display("FAIL stall_hold cyc=%0d got=%h/%b exp=%h/1", c, ifc.out_data, ifc.out_valid, held);
         end
      end
      ifc.out_ready = 1'b1;
      k = 0;
      while (!tx_done && k < 200) begin
         @(negedge clk);
         k++;
      end
      wait_out(4, 100);
      checks++; if (got_q.size() != 4) begin failures++; $display("FAIL stall_count got=%0d exp=4", got_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (i < got_q.size()) ? got_q[i] : 'x;
         checks++; if (g !== exp_q[i]) begin failures++; $display("FAIL stall_out idx=%0d got=%h exp=%h", i, g, exp_q[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [BW-1:0] pa[N];
      logic [BW-1:0] pb[N];
      logic [OW-1:0] g;
      clear_q();
      rand_frame(pa);
      rand_frame(pb);
      model_frame(pa, 2'b00);
      model_frame(pb, 2'b11);
      send_frame(pa, 2'b00, 2'b11, 6, 0);
      send_frame(pb, 2'b11, 2'b00, 9, 0);
      wait_out(8, 100);
      checks++; if (got_q.size() != 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", got_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (i < got_q.size()) ? got_q[i] : 'x;
         checks++; if (g !== exp_q[i]) begin failures++; $display("FAIL b2b_out idx=%0d got=%h exp=%h", i, g, exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid();
      logic [BW-1:0] pa[N];
      logic [BW-1:0] pb[N];
      logic [OW-1:0] g;
      rand_frame(pa);
      rand_frame(pb);
      for (int i = 0; i < 6; i++) send_pix(pa[i], 2'b01, 0);
      ifc.in_valid = 1'b1;
      ifc.in_data  = pa[6];
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", ifc.out_valid); end
      checks++; if (ifc.out_data !== 8'h00) begin failures++; $display("FAIL midrst_out_data got=%h exp=00", ifc.out_data); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      ifc.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      clear_q();
      model_frame(pb, 2'b11);
      send_frame(pb, 2'b11, 2'b11, N, 0);
      wait_out(4, 100);
      checks++; if (got_q.size() != 4) begin failures++; $display("FAIL midrst_count got=%0d exp=4", got_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (i < got_q.size()) ? got_q[i] : 'x;
         checks++; if (g !== exp_q[i]) begin failures++; $display("FAIL midrst_out idx=%0d got=%h exp=%h", i, g, exp_q[i]); end
      end
   endtask

   task automatic test_random();
      logic [BW-1:0] p[N];
      logic [1:0]    m;
      logic [OW-1:0] g;
      clear_q();
      bp_en = 1'b1;
      for (int f = 0; f < 3; f++) begin
         rand_frame(p);
         m = 2'($urandom_range(0, 3));
         model_frame(p, m);
         send_frame(p, m, 2'($urandom_range(0, 3)), 1, 2);
      end
      wait_out(12, 1000);
      bp_en = 1'b0;
      ifc.out_ready = 1'b1;
      checks++; if (got_q.size() != 12) begin failures++; $display("FAIL rand_count got=%0d exp=12", got_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (i < got_q.size()) ? got_q[i] : 'x;
         checks++; if (g !== exp_q[i]) begin failures++; $display("FAIL rand_out idx=%0d got=%h exp=%h", i, g, exp_q[i]); end
      end
   endtask

   initial begin
      ifc.in_valid  = 1'b0;
      ifc.in_data   = '0;
      ifc.out_ready = 1'b1;
      tx_done       = 1'b0;
      @(negedge clk);
      test_reset();
      test_max_ramp();
      test_avg();
      test_nand();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
